// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32 core: stall/flush/forward control plus data-memory wait FSM.
// Latency: stall/flush/forward outputs are combinational; FSM state and stallCount update on posedge clk.
// Backpressure: memory wait freezes all four pipeline registers until memAckM, or forever once timed out (memErr).
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating stallCount counter (tied to 0 otherwise).
module hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             regWriteM,
  input  logic             regWriteW,
  input  logic [1:0]       resultSrcE,
  input  logic             pcSrcE,
  input  logic             memReqM,
  input  logic             memAckM,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             memErr,
  output logic [CNT_W-1:0] stallCount
);

  localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_ERR  = 2'b10
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WCNT_W-1:0] r_wcnt;
  logic [WCNT_W-1:0] w_wcnt_nxt;
  logic              w_mem_stall;
  logic              w_lw_stall;

  // Memory FSM state and wait counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  // Next-state logic and memory stall decode; a dropped request in WAIT still counts toward timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_mem_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (memReqM && !memAckM) begin
          w_state_nxt = S_WAIT;
          w_wcnt_nxt  = '0;
          w_mem_stall = 1'b1;
        end
      end
      S_WAIT: begin
        if (memAckM) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_mem_stall = 1'b1;
          if (r_wcnt == WCNT_LAST) begin
            w_state_nxt = S_ERR;
          end else begin
            w_wcnt_nxt = r_wcnt + WCNT_W'(1);
          end
        end
      end
      S_ERR: begin
        w_mem_stall = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign memErr     = (r_state == S_ERR);
  assign w_lw_stall = (resultSrcE == 2'b01) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // Stall/flush priority: reset clears, memory freeze, taken branch squashes, then load-use bubble.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    if (!rst) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (w_mem_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
    end else if (pcSrcE) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (w_lw_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  // EX operand forwarding, MEM result preferred over WB; forced to the register file during reset.
  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (rst) begin
      if (regWriteM && (RdM != 5'd0) && (RdM == Rs1E))      forwardAE = 2'b10;
      else if (regWriteW && (RdW != 5'd0) && (RdW == Rs1E)) forwardAE = 2'b01;
      if (regWriteM && (RdM != 5'd0) && (RdM == Rs2E))      forwardBE = 2'b10;
      else if (regWriteW && (RdW != 5'd0) && (RdW == Rs2E)) forwardBE = 2'b01;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Count fetch-stall cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (stallF && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stallCount = r_stall_cnt;
`else
  assign stallCount = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32 core. It drives the stall and clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the EX-stage forwarding muxes. It also sequences the data-memory request/acknowledge handshake, freezing the pipeline until memory responds or a timeout fires. It sits beside the datapath and is the single owner of every stall/flush signal.

## Interface
- TIMEOUT, 16, maximum cycles in WAIT before declaring a memory error (≥2)
- CNT_W, 32, width of the stall performance counter
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- Rs1D, Rs2D  in  5  source registers in ID
- Rs1E, Rs2E, RdE  in  5  source/destination registers in EX
- RdM, RdW  in  5  destination registers in MEM/WB
- regWriteM, regWriteW  in  1  register-write enables in MEM/WB
- resultSrcE  in  2  EX result select; 2'b01 = load (memory read data)
- pcSrcE  in  1  taken branch/jump resolved in EX
- memReqM  in  1  MEM-stage instruction accesses data memory
- memAckM  in  1  data memory completes the access this cycle
- stallF, stallD, stallE, stallM  out  1  hold PC / IF-ID / ID-EX / EX-MEM
- flushD, flushE  out  1  clear IF-ID / ID-EX
- forwardAE, forwardBE  out  2  00 register file, 10 from MEM, 01 from WB
- memErr  out  1  sticky memory-timeout flag
- stallCount  out  CNT_W  cycles with stallF=1 (see Configuration)

## Operation
- Memory FSM states: IDLE, WAIT, ERR. The wait counter `wcnt` is ceil(log2(TIMEOUT)) bits.
  - IDLE: memReqM & !memAckM → WAIT with wcnt=0. Otherwise stay in IDLE.
  - WAIT: memAckM → IDLE. Else if wcnt==TIMEOUT-1 → ERR. Else wcnt+1.
  - ERR: terminal until reset; memErr=1.
- memStall = (IDLE & memReqM & !memAckM) | (WAIT & !memAckM) | ERR.
- Zero-wait ack (memReqM & memAckM in IDLE): no stall, FSM stays IDLE.
- Load-use: lwStall = (resultSrcE==2'b01) & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D).
- Output priority:
  1. memStall: stallF=stallD=stallE=stallM=1, flushD=flushE=0. A pending pcSrcE or lwStall takes effect after release.
  2. pcSrcE: flushD=flushE=1, no stalls. A taken branch overrides lwStall because the load-dependent instruction is squashed.
  3. lwStall: stallF=stallD=1, flushE=1.
  4. Otherwise all outputs 0.
- Forwarding, per operand (A uses Rs1E, B uses Rs2E):
  - 10 if regWriteM & RdM!=0 & RdM==RsE.
  - Else 01 if regWriteW & RdW!=0 & RdW==RsE.
  - Else 00.
  - MEM has priority over WB. Forwarding is evaluated during stalls too.

## Timing
- stall*, flush*, and forward* are combinational from inputs and FSM state, with no added latency.
- State, wcnt, memErr, and stallCount are registered on posedge clk.
- While rst=0: state=IDLE, wcnt=0, memErr=0, stallCount=0, stall*=0, flushD=flushE=1, forward*=00. Pipeline registers clear while reset is held.
- Reset asserted mid-WAIT or in ERR returns to IDLE immediately (asynchronous).
- memAckM while the FSM is IDLE and memReqM=0 is ignored.
- memReqM must stay high while stalled. memReqM dropping in WAIT without ack is a protocol violation; the FSM continues counting toward timeout.
- A request taking N≥1 wait cycles stalls the pipeline for exactly N cycles and releases in the cycle memAckM=1.
- Timeout: ERR is entered on the edge after TIMEOUT cycles in WAIT without ack.

## Configuration
- HAZARD_PERF_CNT_EN defined: stallCount increments each cycle stallF=1 and saturates at all-ones (no wrap).
- Not defined: the counter logic is omitted and stallCount is tied to 0. The port is always present.

## Test plan
- Load-use: resultSrcE=01, RdE=5, Rs1D=5 → stallF=stallD=flushE=1 for one cycle. With RdE=0 → no stall.
- Branch plus load-use in the same cycle: pcSrcE=1, lwStall condition true → flushD=flushE=1, stallF=stallD=0.
- Forward priority: regWriteM=regWriteW=1, RdM=RdW=Rs1E=7 → forwardAE=10. With RdM=0 → 01. With Rs2E=3 and no match → forwardBE=00.
- Memory wait: memReqM=1, memAckM held 0 for 3 cycles then 1 → all four stalls high for exactly 3 cycles, FSM back in IDLE, stallCount=3 (macro on). A zero-wait ack gives no stall.
- Timeout: TIMEOUT=4, memReqM=1, no ack → ERR after 4 WAIT cycles, memErr=1, pipeline frozen. Deassert rst → memErr=0, IDLE, flushD=flushE=1 during reset.
